jpeg_idct_ostage: RTL and testbench

Parametrised IDCT output stage. It sits behind the column-pass IDCT calculator, which delivers 32 beats of two fixed-point samples each per 8x8 block. Each sample gets rounding, an optional level shift and saturation, then passes through a block-sized FIFO to a ready/enable consumer. Widths, fraction position, output signedness and FIFO depth are configurable, and the stage adds backpressure, block framing and error flags.

---
 rtl/jpeg_idct_pkg.sv | 48 ++++
 rtl/jpeg_idct_ofifo.sv | 107 ++++++++++
 rtl/jpeg_idct_ostage.sv | 176 +++++++++++++++++
 tb/tb_jpeg_idct_ostage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_idct_pkg.sv
// Shared definitions for the IDCT output stage.
//   BLOCK_BEATS : beats per 8x8 block (32 beats of two samples)
//   beat_t      : one output beat {page, count, last, d0, d1}
//   saturate()  : clamp a wide signed value to a signed/unsigned width
package jpeg_idct_pkg;

    localparam int unsigned BLOCK_BEATS = 32;
    localparam int unsigned PAGE_W      = 3;
    localparam int unsigned COUNT_W     = 2;
    // Widest supported output sample; OUT_WIDTH must be below this.
    localparam int unsigned MAX_OUT_W   = 32;

    typedef struct packed {
        logic [PAGE_W-1:0]    page;
        logic [COUNT_W-1:0]   count;
        logic                 last;
        logic [MAX_OUT_W-1:0] d0;
        logic [MAX_OUT_W-1:0] d1;
    } beat_t;

    // Clamp v to the range of a width-bit number; result is the low width bits,
    // zero-extended to MAX_OUT_W.
    function automatic logic [MAX_OUT_W-1:0] saturate(input logic signed [63:0] v,
                                                      input int unsigned        width,
                                                      input logic               is_signed);
        logic signed [63:0] lo;
        logic signed [63:0] hi;
        logic signed [63:0] r;
        logic signed [63:0] mask;
        if (is_signed) begin
            lo = -(64'sd1 <<< (width - 1));
            hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        end else begin
            lo = 64'sd0;
            hi = (64'sd1 <<< width) - 64'sd1;
        end
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        mask = (64'sd1 <<< width) - 64'sd1;
        return MAX_OUT_W'(r & mask);
    endfunction

endpackage

// File: rtl/jpeg_idct_ofifo.sv
// Synchronous FIFO with a show-ahead output register.
// Capacity is DEPTH beats in total, counting the beat held in the output register.
//   flush_i     : synchronous clear of contents and pointers
//   wr_i/wdata_i: write request; wr_ok_o says it was accepted (not full, or read same edge)
//   rd_i        : consumer ready; a read happens when rvalid_o && rd_i
//   rvalid_o/rdata_o : registered head of the FIFO
//   free_next_o : free entries after the current edge (for a registered "room" flag)
module jpeg_idct_ofifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     wr_ok_o,
    input  logic                     rd_i,
    output logic                     rvalid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   free_next_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic full, pop, push, mem_empty, load_out, mem_we;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        full      = (cnt_q == CNT_W'(DEPTH));
        pop       = out_valid_q & rd_i;
        push      = wr_i & (~full | pop);
        // cnt_q includes the output register; memory holds the rest.
        mem_empty = ((cnt_q - CNT_W'(out_valid_q)) == '0);
        load_out  = ~out_valid_q | pop;

        if (load_out) begin
            if (!mem_empty) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end else if (push) begin
                // Bypass straight into the output register.
                out_valid_d = 1'b1;
                out_data_d  = wdata_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        mem_we = push & ~(load_out & mem_empty);
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            mem_we      = 1'b0;
        end

        wr_ok_o     = push & ~flush_i;
        free_next_o = CNT_W'(DEPTH) - cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rvalid_o = out_valid_q;
    assign rdata_o  = out_data_q;

endmodule

// File: rtl/jpeg_idct_ostage.sv
// IDCT output stage: rounds, level-shifts and saturates two samples per beat,
// checks the page/count sequence, and buffers beats in a show-ahead FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   ProcessInit       : synchronous flush of everything
//   DataIn*           : calculator beats (enable, page, count, two samples)
//   DataInIdle        : room for a whole block
//   DataOut*          : ready/enable output beats with page, count, last flag
//   BlockCount        : accepted Last beats (wraps)
//   Overflow/SeqError : sticky error flags
module jpeg_idct_ostage
    import jpeg_idct_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH  = 9,
    parameter int unsigned FRAC_BITS  = 15,
    parameter int unsigned ROUND      = 1,
    parameter int unsigned SIGNED_OUT = 1,
    parameter int          LEVEL      = 0,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ProcessInit,
    input  logic                 DataInEnable,
    input  logic [2:0]           DataInPage,
    input  logic [1:0]           DataInCount,
    input  logic [IN_WIDTH-1:0]  Data0In,
    input  logic [IN_WIDTH-1:0]  Data1In,
    output logic                 DataInIdle,
    output logic                 DataOutEnable,
    input  logic                 DataOutReady,
    output logic [2:0]           DataOutPage,
    output logic [1:0]           DataOutCount,
    output logic                 DataOutLast,
    output logic [OUT_WIDTH-1:0] Data0Out,
    output logic [OUT_WIDTH-1:0] Data1Out,
    output logic [15:0]          BlockCount,
    output logic                 Overflow,
    output logic                 SeqError
);

    localparam int unsigned XW     = IN_WIDTH + 2;
    localparam int unsigned POS_W  = PAGE_W + COUNT_W;
    localparam int unsigned FW     = POS_W + 1 + 2 * OUT_WIDTH;
    localparam int unsigned FREE_W = $clog2(DEPTH) + 1;
    localparam logic signed [XW-1:0] RND = (ROUND != 0) ? (XW'(1) << (FRAC_BITS - 1)) : '0;

    // FIFO word layout: {page, count, last, d0, d1}
    localparam int unsigned D0_LO   = OUT_WIDTH;
    localparam int unsigned LAST_B  = 2 * OUT_WIDTH;
    localparam int unsigned COUNT_LO = LAST_B + 1;
    localparam int unsigned PAGE_LO  = COUNT_LO + COUNT_W;

    function automatic logic [MAX_OUT_W-1:0] scale_sample(input logic [IN_WIDTH-1:0] din);
        logic signed [XW-1:0] v;
        logic signed [XW-1:0] s;
        v = signed'({{2{din[IN_WIDTH-1]}}, din}) + RND;
        s = v >>> FRAC_BITS;
        return saturate(64'(s) + 64'(LEVEL), OUT_WIDTH, SIGNED_OUT != 0);
    endfunction

    logic              stg_valid_q, stg_valid_d;
    beat_t             stg_beat_q, stg_beat_d;
    logic [POS_W-1:0]  exp_q, exp_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic              ovf_q, ovf_d;
    logic              seq_err_q, seq_err_d;
    logic              idle_q, idle_d;

    logic [POS_W-1:0]  in_pos;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_wr_ok;
    logic              fifo_rvalid;
    logic [FREE_W-1:0] free_next;
    logic              out_pop;

    logic unused_stg_hi;
    assign unused_stg_hi = ^{stg_beat_q.d0[MAX_OUT_W-1:OUT_WIDTH],
                             stg_beat_q.d1[MAX_OUT_W-1:OUT_WIDTH]};

    assign in_pos     = {DataInPage, DataInCount};
    assign fifo_wdata = {stg_beat_q.page, stg_beat_q.count, stg_beat_q.last,
                         stg_beat_q.d0[OUT_WIDTH-1:0], stg_beat_q.d1[OUT_WIDTH-1:0]};
    assign out_pop    = fifo_rvalid & DataOutReady;

    always_comb begin
        stg_valid_d = DataInEnable;
        stg_beat_d  = stg_beat_q;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        ovf_d       = ovf_q;
        blk_cnt_d   = blk_cnt_q;

        if (DataInEnable) begin
            stg_beat_d.page  = DataInPage;
            stg_beat_d.count = DataInCount;
            stg_beat_d.last  = (in_pos == '1);
            stg_beat_d.d0    = scale_sample(Data0In);
            stg_beat_d.d1    = scale_sample(Data1In);
            // A bad beat is kept; the checker resyncs to follow it.
            if (in_pos != exp_q) begin
                seq_err_d = 1'b1;
            end
            exp_d = in_pos + POS_W'(1);
        end

        if (stg_valid_q && !fifo_wr_ok) begin
            ovf_d = 1'b1;
        end
        if (out_pop && fifo_rdata[LAST_B]) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end

        // The beat entering the stage register still needs a FIFO slot.
        idle_d = (32'(free_next) >= BLOCK_BEATS + 32'(stg_valid_d));

        if (ProcessInit) begin
            stg_valid_d = 1'b0;
            stg_beat_d  = '0;
            exp_d       = '0;
            seq_err_d   = 1'b0;
            ovf_d       = 1'b0;
            blk_cnt_d   = '0;
            idle_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_beat_q  <= '0;
            exp_q       <= '0;
            blk_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            seq_err_q   <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_beat_q  <= stg_beat_d;
            exp_q       <= exp_d;
            blk_cnt_q   <= blk_cnt_d;
            ovf_q       <= ovf_d;
            seq_err_q   <= seq_err_d;
            idle_q      <= idle_d;
        end
    end

    jpeg_idct_ofifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_ofifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (ProcessInit),
        .wr_i        (stg_valid_q),
        .wdata_i     (fifo_wdata),
        .wr_ok_o     (fifo_wr_ok),
        .rd_i        (DataOutReady),
        .rvalid_o    (fifo_rvalid),
        .rdata_o     (fifo_rdata),
        .free_next_o (free_next)
    );

    assign DataInIdle    = idle_q;
    assign DataOutEnable = fifo_rvalid;
    assign DataOutPage   = fifo_rdata[PAGE_LO +: PAGE_W];
    assign DataOutCount  = fifo_rdata[COUNT_LO +: COUNT_W];
    assign DataOutLast   = fifo_rdata[LAST_B];
    assign Data0Out      = fifo_rdata[D0_LO +: OUT_WIDTH];
    assign Data1Out      = fifo_rdata[OUT_WIDTH-1:0];
    assign BlockCount    = blk_cnt_q;
    assign Overflow      = ovf_q;
    assign SeqError      = seq_err_q;

endmodule

// File: tb/tb_jpeg_idct_ostage.sv
module tb_jpeg_idct_ostage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ProcessInit, DataInEnable, DataOutReady;
    logic [2:0]  DataInPage;
    logic [1:0]  DataInCount;
    logic [31:0] Data0In, Data1In;

    // Default-parameter DUT
    logic        idle, oen, olast, ovf, serr;
    logic [2:0]  opage;
    logic [1:0]  ocount;
    logic [8:0]  o0, o1;
    logic [15:0] bcnt;
    // Truncating DUT
    logic        t_idle, t_oen, t_last, t_ovf, t_serr;
    logic [2:0]  t_page;
    logic [1:0]  t_count;
    logic [8:0]  t_o0, t_o1;
    logic [15:0] t_bcnt;
    // 8-bit unsigned pixel DUT
    logic        p_idle, p_oen, p_last, p_ovf, p_serr;
    logic [2:0]  p_page;
    logic [1:0]  p_count;
    logic [7:0]  p_o0, p_o1;
    logic [15:0] p_bcnt;

    jpeg_idct_ostage u_dut (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .DataInEnable(DataInEnable),
        .DataInPage(DataInPage), .DataInCount(DataInCount), .Data0In(Data0In),
        .Data1In(Data1In), .DataInIdle(idle), .DataOutEnable(oen),
        .DataOutReady(DataOutReady), .DataOutPage(opage), .DataOutCount(ocount),
        .DataOutLast(olast), .Data0Out(o0), .Data1Out(o1), .BlockCount(bcnt),
        .Overflow(ovf), .SeqError(serr)
    );

    jpeg_idct_ostage #(.ROUND(0)) u_trunc (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .DataInEnable(DataInEnable),
        .DataInPage(DataInPage), .DataInCount(DataInCount), .Data0In(Data0In),
        .Data1In(Data1In), .DataInIdle(t_idle), .DataOutEnable(t_oen),
        .DataOutReady(DataOutReady), .DataOutPage(t_page), .DataOutCount(t_count),
        .DataOutLast(t_last), .Data0Out(t_o0), .Data1Out(t_o1), .BlockCount(t_bcnt),
        .Overflow(t_ovf), .SeqError(t_serr)
    );

    jpeg_idct_ostage #(.OUT_WIDTH(8), .SIGNED_OUT(0), .LEVEL(128)) u_pix (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .DataInEnable(DataInEnable),
        .DataInPage(DataInPage), .DataInCount(DataInCount), .Data0In(Data0In),
        .Data1In(Data1In), .DataInIdle(p_idle), .DataOutEnable(p_oen),
        .DataOutReady(DataOutReady), .DataOutPage(p_page), .DataOutCount(p_count),
        .DataOutLast(p_last), .Data0Out(p_o0), .Data1Out(p_o1), .BlockCount(p_bcnt),
        .Overflow(p_ovf), .SeqError(p_serr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic: floor((x + rounding) / 2^15) + level, clamped.
    function automatic logic [31:0] model(input logic [31:0] din, input int rnd, input int w,
                                          input int sgn, input int level);
        longint v, q, lo, hi;
        v = longint'($signed(din));
        if (rnd != 0) v = v + 16384;
        q = v / 32768;
        if (v < 0 && (v % 32768) != 0) q = q - 1;
        q = q + level;
        lo = (sgn != 0) ? -(longint'(1) << (w - 1)) : 0;
        hi = (sgn != 0) ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        if (q < lo) q = lo;
        if (q > hi) q = hi;
        return 32'(q) & ((32'd1 << w) - 32'd1);
    endfunction

    typedef struct {
        logic [2:0] page;
        logic [1:0] count;
        logic       last;
        logic [8:0] d0;
        logic [8:0] d1;
    } exp_t;

    exp_t exp_q[$];
    int   rx_count = 0;

    // Output monitor: scoreboard for transfers and hold-while-stalled checks.
    logic        prev_stall = 1'b0;
    logic        prev_init  = 1'b0;
    logic [23:0] prev_word  = '0;
    always @(negedge clk) begin
        if (prev_stall && !prev_init) begin
            check("stall_hold_en", oen, 1);
            check("stall_hold_data", {opage, ocount, olast, o0, o1}, prev_word);
        end
        if (oen && DataOutReady && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got beat %0h expected none",
                         {opage, ocount, olast, o0, o1});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_pos", {opage, ocount}, {e.page, e.count});
                check("rx_last", olast, e.last);
                check("rx_d0", o0, e.d0);
                check("rx_d1", o1, e.d1);
            end
            rx_count++;
        end
        prev_stall = oen && !DataOutReady;
        prev_init  = rst || ProcessInit;
        prev_word  = {opage, ocount, olast, o0, o1};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [2:0] pg, input logic [1:0] ct,
                              input logic [31:0] a, input logic [31:0] b, input bit kept);
        exp_t e;
        DataInEnable = 1'b1;
        DataInPage   = pg;
        DataInCount  = ct;
        Data0In      = a;
        Data1In      = b;
        if (kept) begin
            e.page  = pg;
            e.count = ct;
            e.last  = (pg == 3'd7 && ct == 2'd3);
            e.d0    = 9'(model(a, 1, 9, 1, 0));
            e.d1    = 9'(model(b, 1, 9, 1, 0));
            exp_q.push_back(e);
        end
        tick();
        DataInEnable = 1'b0;
    endtask

    function automatic logic [31:0] rand_sample();
        int r;
        if ($urandom_range(0, 1) == 0) return $urandom;
        r = int'($urandom_range(0, 800)) - 400;
        return 32'(r * 32768 + int'($urandom_range(0, 32767)));
    endfunction

    task automatic send_block(input bit kept);
        for (int k = 0; k < 32; k++) begin
            drive_beat(3'(k >> 2), 2'(k & 3), rand_sample(), rand_sample(), kept);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        check(name, idle, 1);
    endtask

    task automatic do_init();
        ProcessInit = 1'b1;
        tick();
        ProcessInit = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_en"}, oen, 0);
        check({tag, "_data"}, {opage, ocount, olast, o0, o1}, 0);
        check({tag, "_bcnt"}, bcnt, 0);
        check({tag, "_flags"}, {ovf, serr}, 0);
        check({tag, "_idle"}, idle, 1);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [8:0]  e_def;
        logic [8:0]  e_trunc;
        logic [7:0]  e_pix;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        int   rx_before;

        tbl[0]  = '{32'h0002_8000, 9'd5,    9'd5,    8'd133};
        tbl[1]  = '{32'h0000_4000, 9'd1,    9'd0,    8'd129};
        tbl[2]  = '{32'hFFFF_C000, 9'd0,    9'h1FF,  8'd128};
        tbl[3]  = '{32'h0096_0000, 9'h0FF,  9'h0FF,  8'd255};
        tbl[4]  = '{32'hFF6A_0000, 9'h100,  9'h100,  8'd0};
        tbl[5]  = '{32'hFFC0_0000, 9'h180,  9'h180,  8'd0};
        tbl[6]  = '{32'h003F_8000, 9'h07F,  9'h07F,  8'd255};
        tbl[7]  = '{32'h0064_0000, 9'h0C8,  9'h0C8,  8'd255};
        tbl[8]  = '{32'h0000_7FFF, 9'd1,    9'd0,    8'd129};
        tbl[9]  = '{32'hFFFF_8000, 9'h1FF,  9'h1FF,  8'd127};
        tbl[10] = '{32'h7FFF_FFFF, 9'h0FF,  9'h0FF,  8'd255};
        tbl[11] = '{32'h8000_0000, 9'h100,  9'h100,  8'd0};

        rst = 1'b1; ProcessInit = 1'b0; DataInEnable = 1'b0; DataOutReady = 1'b1;
        DataInPage = '0; DataInCount = '0; Data0In = '0; Data1In = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_clear("reset");

        // Arithmetic table across three parameter sets; also 2-cycle latency.
        for (int i = 0; i < 12; i++) begin
            drive_beat(3'(i / 4), 2'(i % 4), tbl[i].din, tbl[i].din, 1'b1);
            check("tbl_lat_early", oen, 0);
            tick();
            check("tbl_lat_valid", {oen, t_oen, p_oen}, 3'b111);
            check("tbl_def", {o0, o1}, {tbl[i].e_def, tbl[i].e_def});
            check("tbl_trunc", {t_o0, t_o1}, {tbl[i].e_trunc, tbl[i].e_trunc});
            check("tbl_pix", {p_o0, p_o1}, {tbl[i].e_pix, tbl[i].e_pix});
        end
        tick();
        check("tbl_serr", serr, 0);

        // One full block of 5.0 on both lanes.
        do_init();
        drive_beat(3'd0, 2'd0, 32'h0002_8000, 32'h0002_8000, 1'b1);
        check("blk_lat1", oen, 0);
        for (int k = 1; k < 32; k++) begin
            drive_beat(3'(k >> 2), 2'(k & 3), 32'h0002_8000, 32'h0002_8000, 1'b1);
            if (k == 1) check("blk_lat2", {oen, o0, o1}, {1'b1, 9'd5, 9'd5});
        end
        wait_drain("blk_drain", 100);
        tick();
        check("blk_count", bcnt, 1);

        // Random data, random backpressure, blocks gated by DataInIdle.
        do_init();
        for (int b = 0; b < 4; b++) begin
            DataOutReady = 1'b1;
            wait_idle("rand_idle", 400);
            for (int k = 0; k < 32; k++) begin
                DataOutReady = ($urandom_range(0, 3) != 0);
                drive_beat(3'(k >> 2), 2'(k & 3), rand_sample(), rand_sample(), 1'b1);
            end
        end
        DataOutReady = 1'b1;
        wait_drain("rand_drain", 400);
        tick();
        check("rand_bcnt", bcnt, 4);
        check("rand_flags", {ovf, serr}, 0);

        // Stalled consumer: two blocks fill the FIFO, a third overflows.
        do_init();
        DataOutReady = 1'b0;
        rx_before = rx_count;
        check("stall_idle0", idle, 1);
        send_block(1'b1);
        repeat (3) tick();
        check("stall_idle1", idle, 1);
        send_block(1'b1);
        repeat (3) tick();
        check("stall_idle2", idle, 0);
        check("stall_ovf0", ovf, 0);
        send_block(1'b0);
        repeat (3) tick();
        check("stall_ovf1", ovf, 1);
        check("stall_head", {oen, opage, ocount}, {1'b1, 3'd0, 2'd0});
        DataOutReady = 1'b1;
        wait_drain("stall_drain", 300);
        repeat (5) tick();
        check("stall_rx64", rx_count - rx_before, 64);
        check("stall_bcnt", bcnt, 2);

        // Sequence error and resync.
        do_init();
        drive_beat(3'd2, 2'd1, 32'h0001_0000, 32'h0002_0000, 1'b1);
        repeat (2) tick();
        check("seq_err_set", serr, 1);
        drive_beat(3'd2, 2'd2, 32'h0003_0000, 32'h0004_0000, 1'b1);
        wait_drain("seq_drain", 50);
        check("seq_err_sticky", serr, 1);
        do_init();
        check("seq_err_clear", serr, 0);

        // ProcessInit in the middle of a stalled block.
        DataOutReady = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_beat(3'(k >> 2), 2'(k & 3), rand_sample(), rand_sample(), 1'b1);
        end
        DataInEnable = 1'b1; DataInPage = 3'd2; DataInCount = 2'd2;
        ProcessInit = 1'b1;
        tick();
        DataInEnable = 1'b0; ProcessInit = 1'b0;
        exp_q.delete();
        check_clear("init_mid");
        DataOutReady = 1'b1;
        send_block(1'b1);
        wait_drain("init_drain", 100);
        tick();
        check("init_bcnt", bcnt, 1);
        check("init_flags", {ovf, serr}, 0);

        // Reset in the middle of a stalled block.
        DataOutReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_beat(3'(k >> 2), 2'(k & 3), rand_sample(), rand_sample(), 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_clear("rst_mid");
        DataOutReady = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
